// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory slave for the RV32I pipeline.
// One request at a time; stores commit at acceptance, responses appear
// after a fixed LATENCY and hold until the consumer takes them.
module dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  logic [31:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          err_q, err_d;
  logic [31:0]   word_q, word_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;

  logic          accept_c;
  logic [AW-1:0] idx_c;
  logic          req_err_c;
  logic [3:0]    be_c;
  logic [31:0]   wdata_rep_c;
  logic [7:0]    byte_c;
  logic [15:0]   half_c;
  logic [31:0]   load_c;

  assign accept_c = req_valid && req_ready_q;
  assign idx_c    = req_addr[AW+1:2];

  // Request error check: illegal size, misalignment, or address past the array
  always_comb begin
    req_err_c = 1'b0;
    case (req_size)
      2'd0:    req_err_c = 1'b0;
      2'd1:    req_err_c = req_addr[0];
      2'd2:    req_err_c = |req_addr[1:0];
      default: req_err_c = 1'b1;
    endcase
    if ((req_addr >> (AW + 2)) != 32'd0) begin
      req_err_c = 1'b1;
    end
  end

  // Store lane enables and replicated store data
  always_comb begin
    be_c        = 4'b1111;
    wdata_rep_c = req_wdata;
    case (req_size)
      2'd0: begin
        be_c        = 4'b0001 << req_addr[1:0];
        wdata_rep_c = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        be_c        = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep_c = {2{req_wdata[15:0]}};
      end
      default: begin
        be_c        = 4'b1111;
        wdata_rep_c = req_wdata;
      end
    endcase
  end

  // Memory array: lane-enabled write at acceptance, contents never reset
  always_ff @(posedge clk) begin
    if (accept_c && req_we && !req_err_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) begin
          mem[idx_c][8*i +: 8] <= wdata_rep_c[8*i +: 8];
        end
      end
    end
  end

  // Captured load word, taken at acceptance (pre-write contents)
  always_comb begin
    word_d = word_q;
    if (accept_c) begin
      word_d = mem[idx_c];
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  // Sub-word select and sign/zero extension from the latched request fields
  always_comb begin
    byte_c = word_q[{addr_lo_q, 3'b000} +: 8];
    half_c = word_q[{addr_lo_q[1], 4'b0000} +: 16];
    case (size_q)
      2'd0:    load_c = uns_q ? {24'd0, byte_c} : {{24{byte_c[7]}}, byte_c};
      2'd1:    load_c = uns_q ? {16'd0, half_c} : {{16{half_c[15]}}, half_c};
      default: load_c = word_q;
    endcase
  end

  // Next-state, latency counter and registered response outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_lo_d    = addr_lo_q;
    size_d       = size_q;
    uns_d        = uns_q;
    err_d        = err_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d   = WAIT;
          cnt_d     = '0;
          we_d      = req_we;
          addr_lo_d = req_addr[1:0];
          size_d    = req_size;
          uns_d     = req_unsigned;
          err_d     = req_err_c;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = err_q;
          resp_rdata_d = (we_q || err_q) ? 32'd0 : load_c;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'd0;
          resp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // Control state register with asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_lo_q    <= 2'd0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_lo_q    <= addr_lo_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
